// File: rtl/minmax_tracker_16_pkg.sv
// ---------------------------------------------------------------------------
// minmax_tracker_16_pkg
//
// Purpose: shared definitions for the min/max tracker and its comparator.
//   - DATA_W  : sample width.
//   - state_t : FSM state encoding (2 bits), also driven out on dbg_state.
//   - ready_in_state() : which states accept sample beats.
// ---------------------------------------------------------------------------
package minmax_tracker_16_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Beats are taken only while a batch is open.
    function automatic logic ready_in_state(input state_t s);
        return (s == ST_FIRST) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/minmax_tracker_16_comp.sv
// ---------------------------------------------------------------------------
// comp_16
//
// Purpose: unsigned 16-bit magnitude comparator built as four cascaded
//   4-bit stages in the style of a 7485. The cascade inputs of the least
//   significant stage are tied G=0, E=1, L=0 so that a full-word tie
//   reports "equal".
//
// Ports:
//   i_a      [15:0]  operand A
//   i_b      [15:0]  operand B
//   o_a_g_b          A >  B
//   o_a_e_b          A == B
//   o_a_l_b          A <  B
// ---------------------------------------------------------------------------
module comp_16
    import minmax_tracker_16_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_a_g_b,
    output logic              o_a_e_b,
    output logic              o_a_l_b
);

    localparam int N_NIB = DATA_W / 4;

    // Cascade chain: index 0 is the tied-off input, index k+1 is the output
    // of nibble stage k. The most significant stage produces the result.
    logic [N_NIB:0] w_g;
    logic [N_NIB:0] w_e;
    logic [N_NIB:0] w_l;

    assign w_g[0] = 1'b0;
    assign w_e[0] = 1'b1;
    assign w_l[0] = 1'b0;

    for (genvar k = 0; k < N_NIB; k++) begin : g_stage
        logic [3:0] w_a_nib;
        logic [3:0] w_b_nib;
        logic       w_nib_gt;
        logic       w_nib_eq;
        logic       w_nib_lt;

        assign w_a_nib  = i_a[4*k +: 4];
        assign w_b_nib  = i_b[4*k +: 4];
        assign w_nib_gt = (w_a_nib > w_b_nib);
        assign w_nib_eq = (w_a_nib == w_b_nib);
        assign w_nib_lt = (w_a_nib < w_b_nib);

        // A higher nibble decides on its own; only on a nibble tie does the
        // verdict of the lower stages pass through.
        assign w_g[k+1] = w_nib_gt | (w_nib_eq & w_g[k]);
        assign w_e[k+1] = w_nib_eq & w_e[k];
        assign w_l[k+1] = w_nib_lt | (w_nib_eq & w_l[k]);
    end

    assign o_a_g_b = w_g[N_NIB];
    assign o_a_e_b = w_e[N_NIB];
    assign o_a_l_b = w_l[N_NIB];

endmodule

// File: rtl/minmax_tracker_16.sv
// ---------------------------------------------------------------------------
// minmax_tracker_16
//
// Purpose: consumes a batch of unsigned 16-bit samples and tracks the running
//   maximum and minimum together with the 0-based index of their first
//   occurrence. Results are final while done is high.
//
// Handshake: a beat transfers on a rising clk edge where in_valid and
//   in_ready are both 1. in_ready is registered and depends only on the FSM
//   state; the upstream holds in_data/in_last stable until the transfer.
//   in_last is meaningful only on a transferring beat.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous reset, active-low
//   start      open a new batch (honoured in IDLE or DONE only)
//   in_valid   sample present
//   in_data    unsigned sample [15:0]
//   in_last    final sample of the batch
//   in_ready   block accepts a beat this cycle
//   max_out    largest sample so far [15:0]
//   min_out    smallest sample so far [15:0]
//   max_idx    index of first occurrence of max [CNT_W-1:0]
//   min_idx    index of first occurrence of min [CNT_W-1:0]
//   count      samples accepted, saturating [CNT_W-1:0]
//   ovf        sticky: batch longer than 2^CNT_W-1 samples
//   done       results final
//   dbg_state  current FSM state (state_t encoding) [1:0]
// ---------------------------------------------------------------------------
module minmax_tracker_16
    import minmax_tracker_16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] max_out,
    output logic [DATA_W-1:0] min_out,
    output logic [CNT_W-1:0]  max_idx,
    output logic [CNT_W-1:0]  min_idx,
    output logic [CNT_W-1:0]  count,
    output logic              ovf,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_max;
    logic [DATA_W-1:0]   r_min;
    logic [CNT_W-1:0]    r_max_idx;
    logic [CNT_W-1:0]    r_min_idx;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;
    logic                r_done;

    logic                w_accept;
    logic                w_cnt_sat;
    logic                w_max_gt;
    logic                w_max_eq;
    logic                w_max_lt;
    logic                w_min_gt;
    logic                w_min_eq;
    logic                w_min_lt;
    logic [3:0]          w_unused_cmp;

    assign w_accept  = in_valid & r_in_ready;
    assign w_cnt_sat = (r_count == CNT_MAX);

    // Max path: a strictly greater sample replaces the maximum.
    comp_16 u_cmp_max (
        .i_a     (in_data),
        .i_b     (r_max),
        .o_a_g_b (w_max_gt),
        .o_a_e_b (w_max_eq),
        .o_a_l_b (w_max_lt)
    );

    // Min path: a strictly smaller sample replaces the minimum.
    comp_16 u_cmp_min (
        .i_a     (in_data),
        .i_b     (r_min),
        .o_a_g_b (w_min_gt),
        .o_a_e_b (w_min_eq),
        .o_a_l_b (w_min_lt)
    );

    // Only one verdict per comparator drives an update; ties keep the
    // earlier occurrence.
    assign w_unused_cmp = {w_max_eq, w_max_lt, w_min_gt, w_min_eq};

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_FIRST;
            end
            ST_FIRST: begin
                if (w_accept) w_next_state = in_last ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_accept && in_last) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (start) w_next_state = ST_FIRST;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // State register and datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_max      <= '0;
            r_min      <= '1;
            r_max_idx  <= '0;
            r_min_idx  <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            // Registered from the next state so in_ready lines up with the
            // state it describes.
            r_in_ready <= ready_in_state(w_next_state);
            r_done     <= (w_next_state == ST_DONE);

            case (r_state)
                ST_IDLE, ST_DONE: begin
                    // Opening a batch clears the tallies; max/min/indices
                    // keep their old values until the first beat lands.
                    if (start) begin
                        r_count <= '0;
                        r_ovf   <= 1'b0;
                    end
                end
                ST_FIRST: begin
                    if (w_accept) begin
                        r_max     <= in_data;
                        r_min     <= in_data;
                        r_max_idx <= '0;
                        r_min_idx <= '0;
                        r_count   <= CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        // r_count equals the index of this beat until the
                        // counter saturates; after that indices pin at max.
                        if (w_max_gt) begin
                            r_max     <= in_data;
                            r_max_idx <= r_count;
                        end
                        if (w_min_lt) begin
                            r_min     <= in_data;
                            r_min_idx <= r_count;
                        end
                        if (w_cnt_sat) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign max_out   = r_max;
    assign min_out   = r_min;
    assign max_idx   = r_max_idx;
    assign min_idx   = r_min_idx;
    assign count     = r_count;
    assign ovf       = r_ovf;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_minmax_tracker_16.sv
module tb_minmax_tracker_16;
  import minmax_tracker_16_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_last = 1'b0;

  logic        rdy8, ovf8, done8;
  logic [15:0] max8, min8;
  logic [7:0]  maxi8, mini8, cnt8;
  logic [1:0]  st8;

  logic        rdy2, ovf2, done2;
  logic [15:0] max2, min2;
  logic [1:0]  maxi2, mini2, cnt2;
  logic [1:0]  st2;

  minmax_tracker_16 #(.CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(rdy8),
    .max_out(max8), .min_out(min8), .max_idx(maxi8), .min_idx(mini8),
    .count(cnt8), .ovf(ovf8), .done(done8), .dbg_state(st8)
  );

  minmax_tracker_16 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(rdy2),
    .max_out(max2), .min_out(min2), .max_idx(maxi2), .min_idx(mini2),
    .count(cnt2), .ovf(ovf2), .done(done2), .dbg_state(st2)
  );

  // ---------------- reference model ----------------
  int total = 0;
  int bad = 0;
  logic [15:0] cur_q[$];
  logic [15:0] prev_q[$];
  state_t exp_state = ST_IDLE;

  // Results implied by the samples seen: the open batch if it has any
  // samples, else the last finished batch, else the reset values.
  function automatic void model(input int maxc, output logic [15:0] mx,
                                output logic [15:0] mn, output int mxi,
                                output int mni, output int cnt, output bit ov);
    logic [15:0] s[$];
    s = (cur_q.size() > 0) ? cur_q : prev_q;
    mx = 16'h0000; mn = 16'hFFFF; mxi = 0; mni = 0;
    if (s.size() > 0) begin
      mx = s[0]; mn = s[0];
      for (int i = 1; i < s.size(); i++) begin
        if (s[i] > mx) begin mx = s[i]; mxi = (i > maxc) ? maxc : i; end
        if (s[i] < mn) begin mn = s[i]; mni = (i > maxc) ? maxc : i; end
      end
    end
    cnt = (cur_q.size() > maxc) ? maxc : cur_q.size();
    ov  = (cur_q.size() > maxc);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] mx, mn;
    int mxi, mni, cnt;
    bit ov;
    logic er;
    er = (exp_state == ST_FIRST) || (exp_state == ST_RUN);
    model(255, mx, mn, mxi, mni, cnt, ov);
    chk({tag, "/max8"},  32'(max8),  32'(mx));
    chk({tag, "/min8"},  32'(min8),  32'(mn));
    chk({tag, "/maxi8"}, 32'(maxi8), 32'(mxi));
    chk({tag, "/mini8"}, 32'(mini8), 32'(mni));
    chk({tag, "/cnt8"},  32'(cnt8),  32'(cnt));
    chk({tag, "/ovf8"},  32'(ovf8),  32'(ov));
    chk({tag, "/done8"}, 32'(done8), 32'(exp_state == ST_DONE));
    chk({tag, "/rdy8"},  32'(rdy8),  32'(er));
    chk({tag, "/st8"},   32'(st8),   32'(exp_state));
    model(3, mx, mn, mxi, mni, cnt, ov);
    chk({tag, "/max2"},  32'(max2),  32'(mx));
    chk({tag, "/min2"},  32'(min2),  32'(mn));
    chk({tag, "/maxi2"}, 32'(maxi2), 32'(mxi));
    chk({tag, "/mini2"}, 32'(mini2), 32'(mni));
    chk({tag, "/cnt2"},  32'(cnt2),  32'(cnt));
    chk({tag, "/ovf2"},  32'(ovf2),  32'(ov));
    chk({tag, "/done2"}, 32'(done2), 32'(exp_state == ST_DONE));
    chk({tag, "/rdy2"},  32'(rdy2),  32'(er));
    chk({tag, "/st2"},   32'(st2),   32'(exp_state));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n, input bit valid_during);
    rst_n = 1'b0;
    in_valid = valid_during;
    in_data = 16'h7777;
    in_last = 1'b0;
    repeat (n) step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    cur_q.delete();
    prev_q.delete();
    exp_state = ST_IDLE;
    check_all("reset");
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    if (exp_state == ST_DONE) begin
      prev_q = cur_q;
      cur_q.delete();
      exp_state = ST_FIRST;
    end else if (exp_state == ST_IDLE) begin
      exp_state = ST_FIRST;
    end
    check_all(tag);
  endtask

  task automatic send(input logic [15:0] d, input bit last, input int gap, input bit chk_each);
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data = 16'($urandom_range(0, 65535));
      in_last = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b1;
    in_data = d;
    in_last = last;
    n = 0;
    while (!rdy8 && n < 20) begin step(); n++; end
    if (!rdy8) chk("ready_wait", 32'(rdy8), 32'd1);
    step();
    cur_q.push_back(d);
    exp_state = last ? ST_DONE : ST_RUN;
    in_valid = 1'b0;
    in_last = 1'b0;
    if (chk_each) check_all("beat");
  endtask

  task automatic rand_batch(input int len, input int hi, input int maxgap);
    pulse_start("rb_start");
    for (int i = 0; i < len; i++)
      send(16'($urandom_range(0, hi)), (i == len - 1), $urandom_range(0, maxgap), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    // Reset then idle: valid held high, nothing happens without start.
    do_reset(2, 1'b1);
    in_valid = 1'b1;
    in_data = 16'h4321;
    repeat (3) step();
    in_valid = 1'b0;
    check_all("idle_hold");
    chk("idle_min", 32'(min8), 32'hFFFF);

    // Basic batch.
    pulse_start("basic_start");
    send(16'h0005, 1'b0, 0, 1'b1);
    send(16'h00A0, 1'b0, 0, 1'b1);
    send(16'h0003, 1'b0, 0, 1'b1);
    send(16'h00A0, 1'b1, 0, 1'b1);
    chk("basic_max",  32'(max8),  32'h00A0);
    chk("basic_maxi", 32'(maxi8), 32'd1);
    chk("basic_min",  32'(min8),  32'h0003);
    chk("basic_mini", 32'(mini8), 32'd2);
    chk("basic_cnt",  32'(cnt8),  32'd4);
    chk("basic_done", 32'(done8), 32'd1);
    step();
    check_all("done_hold");

    // Single-sample batch.
    pulse_start("single_start");
    send(16'h1234, 1'b1, 0, 1'b1);
    chk("single_max", 32'(max8), 32'h1234);
    chk("single_min", 32'(min8), 32'h1234);
    chk("single_cnt", 32'(cnt8), 32'd1);

    // Back-pressure gaps and an ignored start mid-RUN.
    pulse_start("bp_start");
    send(16'h0100, 1'b0, 2, 1'b1);
    send(16'h0050, 1'b0, 3, 1'b1);
    pulse_start("midrun_start");
    send(16'h0200, 1'b0, 1, 1'b1);
    send(16'h0050, 1'b1, 2, 1'b1);
    pulse_start("restart");
    send(16'hFFFF, 1'b0, 0, 1'b1);
    send(16'h0000, 1'b1, 0, 1'b1);
    chk("rs_max",  32'(max8),  32'hFFFF);
    chk("rs_maxi", 32'(maxi8), 32'd0);
    chk("rs_min",  32'(min8),  32'h0000);
    chk("rs_mini", 32'(mini8), 32'd1);
    chk("rs_cnt",  32'(cnt8),  32'd2);

    // Saturation on the CNT_W=2 instance.
    pulse_start("sat_start");
    for (int i = 1; i <= 5; i++) send(16'(i), (i == 5), 0, 1'b1);
    chk("sat_cnt2",  32'(cnt2),  32'd3);
    chk("sat_ovf2",  32'(ovf2),  32'd1);
    chk("sat_max2",  32'(max2),  32'd5);
    chk("sat_maxi2", 32'(maxi2), 32'd3);
    chk("sat_min2",  32'(min2),  32'd1);
    chk("sat_cnt8",  32'(cnt8),  32'd5);

    // Reset mid-RUN, with a beat offered during the reset cycle.
    pulse_start("mr_start");
    send(16'h0011, 1'b0, 0, 1'b1);
    send(16'h0022, 1'b0, 0, 1'b1);
    do_reset(1, 1'b1);
    step();
    check_all("mr_idle");
    pulse_start("mr_basic");
    send(16'h0005, 1'b0, 0, 1'b1);
    send(16'h00A0, 1'b0, 0, 1'b1);
    send(16'h0003, 1'b0, 0, 1'b1);
    send(16'h00A0, 1'b1, 0, 1'b1);
    chk("mr_maxi", 32'(maxi8), 32'd1);
    chk("mr_mini", 32'(mini8), 32'd2);

    // Random batches: wide and narrow value ranges (the latter forces ties).
    for (int b = 0; b < 12; b++)
      rand_batch($urandom_range(1, 20), (b % 2) ? 3 : 65535, 3);

    // Long batch saturating the CNT_W=8 counter.
    pulse_start("long_start");
    for (int i = 0; i < 262; i++)
      send(16'($urandom_range(0, 65535)), (i == 261), 0, (i > 250));
    check_all("long_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
